// File: rtl/tcdm_upcast_pkg.sv
// Shared helpers for the narrow-to-wide TCDM adapter: lane offset extraction,
// wide-word address alignment and sideband entry sizing.
package tcdm_upcast_pkg;

    localparam int unsigned DEF_SLV_WIDTH = 32;
    localparam int unsigned DEF_MAS_WIDTH = 128;

    function automatic int unsigned off_width(input int unsigned slv_w, input int unsigned mas_w);
        return ((mas_w / slv_w) > 1) ? $clog2(mas_w / slv_w) : 1;
    endfunction

    function automatic int unsigned entry_width(input int unsigned slv_w, input int unsigned mas_w);
        return off_width(slv_w, mas_w) + 1;
    endfunction

    // Sideband entry layout is {lane offset, write flag}.
    localparam int unsigned DEF_OFF_W   = off_width(DEF_SLV_WIDTH, DEF_MAS_WIDTH);
    localparam int unsigned DEF_ENTRY_W = DEF_OFF_W + 1;

    function automatic int unsigned lane_offset(input logic [63:0] addr,
                                                input int unsigned slv_w,
                                                input int unsigned mas_w);
        logic [63:0] w_idx;
        w_idx = (addr >> $clog2(slv_w / 8)) & (64'(mas_w / slv_w) - 64'd1);
        return w_idx[31:0];
    endfunction

    function automatic logic [63:0] align_addr(input logic [63:0] addr, input int unsigned mas_w);
        return addr & ~(64'(mas_w / 8) - 64'd1);
    endfunction

endpackage

// File: rtl/tcdm_sideband_fifo.sv
// First-word fall-through FIFO holding per-transaction sideband entries.
// Depth need not be a power of two; pointers wrap explicitly.
module tcdm_sideband_fifo #(
    parameter int unsigned DATA_W = 3,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [DATA_W-1:0]          wdata_i,
    output logic [DATA_W-1:0]          rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       overflow_o,
    output logic                       underflow_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic w_do_push;
    logic w_do_pop;

    assign full_o      = (r_count == CNT_W'(DEPTH));
    assign empty_o     = (r_count == '0);
    assign count_o     = r_count;
    assign overflow_o  = push_i & full_o;
    assign underflow_o = pop_i & empty_o;
    assign w_do_push   = push_i & ~full_o;
    assign w_do_pop    = pop_i & ~empty_o;
    assign rdata_o     = r_mem[r_rd_ptr];

    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/tcdm_upcast_ot.sv
// Narrow-to-wide TCDM adapter: requests are re-laned combinationally, and a
// sideband FIFO remembers each lane offset so in-order responses can be de-laned.
module tcdm_upcast_ot
    import tcdm_upcast_pkg::*;
#(
    parameter int unsigned SLV_WIDTH       = 32,
    parameter int unsigned MAS_WIDTH       = 128,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter bit          WRITE_RESP      = 1'b1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 slv_req_i,
    output logic                                 slv_gnt_o,
    input  logic [ADDR_WIDTH-1:0]                slv_addr_i,
    input  logic                                 slv_wen_i,
    input  logic [SLV_WIDTH-1:0]                 slv_data_i,
    input  logic [SLV_WIDTH/8-1:0]               slv_be_i,
    output logic [SLV_WIDTH-1:0]                 slv_r_data_o,
    output logic                                 slv_r_valid_o,
    input  logic                                 slv_r_ready_i,
    output logic                                 mst_req_o,
    input  logic                                 mst_gnt_i,
    output logic [ADDR_WIDTH-1:0]                mst_addr_o,
    output logic                                 mst_wen_o,
    output logic [MAS_WIDTH-1:0]                 mst_data_o,
    output logic [MAS_WIDTH/8-1:0]               mst_be_o,
    input  logic [MAS_WIDTH-1:0]                 mst_r_data_i,
    input  logic                                 mst_r_valid_i,
    output logic                                 mst_r_ready_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                                 err_o
);

    localparam int unsigned OFF_W   = off_width(SLV_WIDTH, MAS_WIDTH);
    localparam int unsigned ENTRY_W = OFF_W + 1;
    localparam int unsigned MBE_W   = MAS_WIDTH / 8;
    localparam int unsigned SBE_W   = SLV_WIDTH / 8;

    logic [OFF_W-1:0]     w_offset;
    logic                 w_tracked;
    logic                 w_stall;
    logic                 w_push;
    logic                 w_pop_req;
    logic [ENTRY_W-1:0]   w_head;
    logic [OFF_W-1:0]     w_head_off;
    logic                 w_head_wen;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic                 w_overflow;
    logic                 w_underflow;
    logic [MAS_WIDTH-1:0] w_r_shift;
    logic                 r_err;

    assign w_offset  = OFF_W'(lane_offset(64'(slv_addr_i), SLV_WIDTH, MAS_WIDTH));
    assign w_tracked = ~slv_wen_i | WRITE_RESP;

    assign mst_addr_o = ADDR_WIDTH'(align_addr(64'(slv_addr_i), MAS_WIDTH));
    assign mst_data_o = MAS_WIDTH'(slv_data_i) << (w_offset * SLV_WIDTH);
    assign mst_be_o   = MBE_W'(slv_be_i) << (w_offset * SBE_W);
    assign mst_wen_o  = slv_wen_i;

    // A full FIFO stalls regardless of a same-cycle pop, keeping r_ready off the gnt path.
    assign w_stall   = w_tracked & w_fifo_full;
    assign mst_req_o = slv_req_i & ~w_stall;
    assign slv_gnt_o = mst_gnt_i & ~w_stall;
    assign w_push    = slv_req_i & slv_gnt_o & w_tracked;
    assign w_pop_req = mst_r_valid_i & slv_r_ready_i;

    tcdm_sideband_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (MAX_OUTSTANDING)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (w_push),
        .pop_i       (w_pop_req),
        .wdata_i     ({w_offset, slv_wen_i}),
        .rdata_o     (w_head),
        .full_o      (w_fifo_full),
        .empty_o     (w_fifo_empty),
        .count_o     (outstanding_o),
        .overflow_o  (w_overflow),
        .underflow_o (w_underflow)
    );

    // An unexpected response (empty FIFO) is passed through as a read at lane 0.
    assign w_head_off = w_fifo_empty ? '0 : w_head[ENTRY_W-1:1];
    assign w_head_wen = ~w_fifo_empty & w_head[0];
    assign w_r_shift  = mst_r_data_i >> (w_head_off * SLV_WIDTH);

    assign slv_r_valid_o = mst_r_valid_i;
    assign mst_r_ready_o = slv_r_ready_i;
    assign slv_r_data_o  = w_head_wen ? '0 : w_r_shift[SLV_WIDTH-1:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else if ((mst_r_valid_i & w_fifo_empty) | w_overflow | w_underflow) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;

endmodule

// File: tb/tb_tcdm_upcast_ot.sv
// Bench for tcdm_upcast_ot: directed scenarios on a 32->128 instance and
// randomized traffic on a 64->64, depth-3 instance, both against a queue model.
module tb_tcdm_upcast_ot;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // 32 -> 128, depth 4 instance
    logic         rst, req, wen, mgnt, rvalid, rready;
    logic [31:0]  addr, wdata;
    logic [3:0]   be;
    logic [127:0] mrdata;
    logic         sgnt, srvalid, mreq, mwen, mrready, err;
    logic [31:0]  srdata, maddr;
    logic [127:0] mdata;
    logic [15:0]  mbe;
    logic [2:0]   outst;

    // 64 -> 64, depth 3 instance
    logic         b_rst, b_req, b_wen, b_mgnt, b_rvalid, b_rready;
    logic [31:0]  b_addr;
    logic [63:0]  b_wdata, b_mrdata;
    logic [7:0]   b_be;
    logic         b_sgnt, b_srvalid, b_mreq, b_mwen, b_mrready, b_err;
    logic [63:0]  b_srdata, b_mdata;
    logic [31:0]  b_maddr;
    logic [7:0]   b_mbe;
    logic [1:0]   b_outst;

    // Model of transactions in flight on the main instance: lane offset and write flag.
    int   off_q[$];
    logic wen_q[$];

    tcdm_upcast_ot #(
        .SLV_WIDTH(32), .MAS_WIDTH(128), .ADDR_WIDTH(32), .MAX_OUTSTANDING(4), .WRITE_RESP(1'b1)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .slv_req_i(req), .slv_gnt_o(sgnt), .slv_addr_i(addr), .slv_wen_i(wen),
        .slv_data_i(wdata), .slv_be_i(be), .slv_r_data_o(srdata), .slv_r_valid_o(srvalid),
        .slv_r_ready_i(rready), .mst_req_o(mreq), .mst_gnt_i(mgnt), .mst_addr_o(maddr),
        .mst_wen_o(mwen), .mst_data_o(mdata), .mst_be_o(mbe), .mst_r_data_i(mrdata),
        .mst_r_valid_i(rvalid), .mst_r_ready_o(mrready), .outstanding_o(outst), .err_o(err)
    );

    tcdm_upcast_ot #(
        .SLV_WIDTH(64), .MAS_WIDTH(64), .ADDR_WIDTH(32), .MAX_OUTSTANDING(3), .WRITE_RESP(1'b1)
    ) dut_b (
        .clk_i(clk), .rst_i(b_rst),
        .slv_req_i(b_req), .slv_gnt_o(b_sgnt), .slv_addr_i(b_addr), .slv_wen_i(b_wen),
        .slv_data_i(b_wdata), .slv_be_i(b_be), .slv_r_data_o(b_srdata), .slv_r_valid_o(b_srvalid),
        .slv_r_ready_i(b_rready), .mst_req_o(b_mreq), .mst_gnt_i(b_mgnt), .mst_addr_o(b_maddr),
        .mst_wen_o(b_mwen), .mst_data_o(b_mdata), .mst_be_o(b_mbe), .mst_r_data_i(b_mrdata),
        .mst_r_valid_i(b_rvalid), .mst_r_ready_o(b_mrready), .outstanding_o(b_outst), .err_o(b_err)
    );

    // Expected narrow response: the selected 32-bit word of a read, zero for a write.
    function automatic logic [31:0] exp_word(input logic [127:0] d, input int off, input logic w);
        logic [127:0] sh;
        sh = d >> (32 * off);
        return w ? 32'h0 : sh[31:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for a cycle; records it in the model if granted.
    task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] b, output logic g);
        req = 1'b1; addr = a; wen = w; wdata = d; be = b;
        @(negedge clk);
        g = sgnt;
        @(posedge clk);
        #1;
        req = 1'b0;
        if (g) begin
            off_q.push_back(int'((a >> 2) & 32'd3));
            wen_q.push_back(w);
        end
    endtask

    // Delivers one wide response with r_ready high; returns the narrow data seen.
    task automatic respond(input logic [127:0] d, output logic [31:0] obs);
        rvalid = 1'b1; rready = 1'b1; mrdata = d;
        @(negedge clk);
        obs = srdata;
        @(posedge clk);
        #1;
        rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; wen = 1'b0; mgnt = 1'b1; rvalid = 1'b0; rready = 1'b1;
        addr = '0; wdata = '0; be = '0; mrdata = '0;
        b_rst = 1'b1; b_req = 1'b0; b_wen = 1'b0; b_mgnt = 1'b0; b_rvalid = 1'b0; b_rready = 1'b0;
        b_addr = '0; b_wdata = '0; b_be = '0; b_mrdata = '0;
        step();
        @(negedge clk);
        checks++;
        if (sgnt !== 1'b1) begin
            failures++; $display("FAIL reset_gnt_follows: got %b expected 1", sgnt);
        end
        step();
        rst = 1'b0; b_rst = 1'b0;
        step();
        checks++;
        if (outst !== 3'd0) begin
            failures++; $display("FAIL reset_outstanding: got %0d expected 0", outst);
        end
        checks++;
        if (err !== 1'b0 || b_err !== 1'b0) begin
            failures++; $display("FAIL reset_err: got %b/%b expected 0/0", err, b_err);
        end
        checks++;
        if (b_outst !== 2'd0) begin
            failures++; $display("FAIL reset_outstanding_b: got %0d expected 0", b_outst);
        end
    endtask

    task automatic test_request_path();
        logic [127:0] ed;
        logic [15:0]  eb;
        int           off;
        req = 1'b0;
        for (int i = 0; i < 12; i++) begin
            addr = $urandom; wdata = $urandom; be = 4'($urandom); wen = 1'($urandom);
            off = int'((addr >> 2) & 32'd3);
            ed = {96'h0, wdata} << (32 * off);
            eb = {12'h0, be} << (4 * off);
            @(negedge clk);
            checks++;
            if (maddr !== (addr & 32'hFFFF_FFF0) || mwen !== wen || mreq !== 1'b0) begin
                failures++;
                $display("FAIL req_addr: got addr=%h wen=%b req=%b expected addr=%h wen=%b req=0",
                         maddr, mwen, mreq, addr & 32'hFFFF_FFF0, wen);
            end
            checks++;
            if (mdata !== ed || mbe !== eb) begin
                failures++;
                $display("FAIL req_lane: got data=%h be=%h expected data=%h be=%h", mdata, mbe, ed, eb);
            end
            step();
        end
    endtask

    task automatic test_write();
        logic [127:0] d;
        req = 1'b1; wen = 1'b1; addr = 32'h108; wdata = 32'hDEADBEEF; be = 4'hF; mgnt = 1'b1;
        @(negedge clk);
        checks++;
        if (maddr !== 32'h100 || mdata !== 128'h0000_0000_DEADBEEF_0000_0000_0000_0000 ||
            mbe !== 16'h0F00 || mreq !== 1'b1 || sgnt !== 1'b1) begin
            failures++;
            $display("FAIL write_request: got addr=%h data=%h be=%h req=%b gnt=%b expected 100/DEADBEEF<<64/0F00/1/1",
                     maddr, mdata, mbe, mreq, sgnt);
        end
        step();
        req = 1'b0;
        off_q.push_back(2); wen_q.push_back(1'b1);
        repeat (2) begin
            checks++;
            if (outst !== 3'd1) begin
                failures++; $display("FAIL write_outstanding: got %0d expected 1", outst);
            end
            step();
        end
        d = {$urandom, $urandom, $urandom, $urandom};
        rvalid = 1'b1; rready = 1'b1; mrdata = d;
        @(negedge clk);
        checks++;
        if (srvalid !== 1'b1 || mrready !== 1'b1 ||
            srdata !== exp_word(d, off_q.pop_front(), wen_q.pop_front())) begin
            failures++;
            $display("FAIL write_response: got valid=%b ready=%b data=%h expected 1/1/00000000",
                     srvalid, mrready, srdata);
        end
        step();
        rvalid = 1'b0;
        checks++;
        if (outst !== 3'd0 || err !== 1'b0) begin
            failures++; $display("FAIL write_retire: got outst=%0d err=%b expected 0/0", outst, err);
        end
    endtask

    task automatic test_back_to_back();
        logic         g;
        logic [31:0]  obs, ex;
        logic [127:0] d;
        d = 128'h44444444_33333333_22222222_11111111;
        mgnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(32'(4 * i), 1'b0, 32'h0, 4'hF, g);
            checks++;
            if (g !== 1'b1) begin
                failures++; $display("FAIL b2b_grant: read %0d got gnt=%b expected 1", i, g);
            end
        end
        step(); step();
        for (int i = 0; i < 4; i++) begin
            respond(d, obs);
            ex = exp_word(d, off_q.pop_front(), wen_q.pop_front());
            checks++;
            if (obs !== ex) begin
                failures++; $display("FAIL b2b_data: response %0d got %h expected %h", i, obs, ex);
            end
        end
        checks++;
        if (outst !== 3'd0) begin
            failures++; $display("FAIL b2b_drain: got %0d expected 0", outst);
        end
    endtask

    task automatic test_stall();
        logic         g;
        logic [31:0]  obs, ex;
        logic [127:0] d;
        mgnt = 1'b1;
        for (int i = 0; i < 4; i++) issue($urandom & 32'hFFFF_FFFC, 1'b0, 32'h0, 4'hF, g);
        checks++;
        if (outst !== 3'd4) begin
            failures++; $display("FAIL stall_fill: got %0d expected 4", outst);
        end
        req = 1'b1; wen = 1'b0; addr = $urandom & 32'hFFFF_FFFC;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (sgnt !== 1'b0 || mreq !== 1'b0) begin
                failures++; $display("FAIL stall_full: got gnt=%b req=%b expected 0/0", sgnt, mreq);
            end
            step();
        end
        d = {$urandom, $urandom, $urandom, $urandom};
        rvalid = 1'b1; rready = 1'b1; mrdata = d;
        @(negedge clk);
        ex = exp_word(d, off_q.pop_front(), wen_q.pop_front());
        checks++;
        if (sgnt !== 1'b0 || srdata !== ex) begin
            failures++;
            $display("FAIL stall_pop_cycle: got gnt=%b data=%h expected 0/%h", sgnt, srdata, ex);
        end
        step();
        rvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (sgnt !== 1'b1 || mreq !== 1'b1 || outst !== 3'd3) begin
            failures++;
            $display("FAIL stall_release: got gnt=%b req=%b outst=%0d expected 1/1/3", sgnt, mreq, outst);
        end
        step();
        req = 1'b0;
        off_q.push_back(int'((addr >> 2) & 32'd3)); wen_q.push_back(1'b0);
        checks++;
        if (outst !== 3'd4) begin
            failures++; $display("FAIL stall_refill: got %0d expected 4", outst);
        end
        while (off_q.size() > 0) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            respond(d, obs);
            ex = exp_word(d, off_q.pop_front(), wen_q.pop_front());
            checks++;
            if (obs !== ex) begin
                failures++; $display("FAIL stall_drain: got %h expected %h", obs, ex);
            end
        end
    endtask

    task automatic test_backpressure();
        logic         g;
        logic [31:0]  obs, ex;
        logic [127:0] d;
        mgnt = 1'b1;
        for (int i = 0; i < 2; i++) issue($urandom, 1'b0, 32'h0, 4'hF, g);
        d = {$urandom, $urandom, $urandom, $urandom};
        ex = exp_word(d, off_q[0], wen_q[0]);
        rvalid = 1'b1; rready = 1'b0; mrdata = d;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (srdata !== ex || srvalid !== 1'b1 || mrready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold: got data=%h valid=%b ready=%b expected %h/1/0", srdata, srvalid, mrready, ex);
            end
            step();
            checks++;
            if (outst !== 3'd2) begin
                failures++; $display("FAIL bp_outstanding: got %0d expected 2", outst);
            end
        end
        rready = 1'b1; req = 1'b1; wen = 1'b0; addr = $urandom;
        @(negedge clk);
        checks++;
        if (sgnt !== 1'b1 || srdata !== ex) begin
            failures++; $display("FAIL bp_push_pop: got gnt=%b data=%h expected 1/%h", sgnt, srdata, ex);
        end
        step();
        rvalid = 1'b0; req = 1'b0;
        void'(off_q.pop_front()); void'(wen_q.pop_front());
        off_q.push_back(int'((addr >> 2) & 32'd3)); wen_q.push_back(1'b0);
        checks++;
        if (outst !== 3'd2) begin
            failures++; $display("FAIL bp_count_same: got %0d expected 2", outst);
        end
        while (off_q.size() > 0) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            respond(d, obs);
            ex = exp_word(d, off_q.pop_front(), wen_q.pop_front());
            checks++;
            if (obs !== ex) begin
                failures++; $display("FAIL bp_drain: got %h expected %h", obs, ex);
            end
        end
    endtask

    task automatic test_error();
        logic         g;
        logic [31:0]  obs;
        logic [127:0] d;
        mgnt = 1'b1;
        for (int i = 0; i < 2; i++) issue($urandom, 1'b0, 32'h0, 4'hF, g);
        rst = 1'b1;
        step();
        rst = 1'b0;
        off_q.delete(); wen_q.delete();
        checks++;
        if (outst !== 3'd0 || err !== 1'b0) begin
            failures++; $display("FAIL err_reset_inflight: got outst=%0d err=%b expected 0/0", outst, err);
        end
        d = {$urandom, $urandom, $urandom, $urandom};
        respond(d, obs);
        checks++;
        if (obs !== d[31:0]) begin
            failures++; $display("FAIL err_passthrough: got %h expected %h", obs, d[31:0]);
        end
        checks++;
        if (err !== 1'b1) begin
            failures++; $display("FAIL err_set: got %b expected 1", err);
        end
        repeat (3) step();
        checks++;
        if (err !== 1'b1 || outst !== 3'd0) begin
            failures++; $display("FAIL err_sticky: got err=%b outst=%0d expected 1/0", err, outst);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (err !== 1'b0 || outst !== 3'd0) begin
            failures++; $display("FAIL err_clear: got err=%b outst=%0d expected 0/0", err, outst);
        end
    endtask

    // Random traffic on the 64/64 depth-3 instance with an in-order slave model.
    task automatic test_random_ratio1();
        logic bq[$];
        logic hs_last, full, exp_gnt, hs_req, hs_resp;
        int   done, cyc, max_cnt;
        done = 0; cyc = 0; max_cnt = 0; hs_last = 1'b0;
        while (done < 1000 && cyc < 30000) begin
            cyc++;
            b_req = 1'($urandom_range(0, 1)); b_wen = 1'($urandom_range(0, 1));
            b_addr = $urandom; b_wdata = {$urandom, $urandom}; b_be = 8'($urandom);
            b_mgnt = ($urandom_range(0, 9) < 7); b_rready = ($urandom_range(0, 9) < 7);
            if (hs_last) b_rvalid = 1'b0;
            if (!b_rvalid && bq.size() > 0 && $urandom_range(0, 9) < 4) begin
                b_rvalid = 1'b1; b_mrdata = {$urandom, $urandom};
            end
            @(negedge clk);
            full    = (bq.size() == 3);
            exp_gnt = b_mgnt & ~full;
            checks++;
            if (b_sgnt !== exp_gnt || b_mreq !== (b_req & ~full)) begin
                failures++;
                $display("FAIL rnd_admit: cyc %0d got gnt=%b req=%b expected %b/%b",
                         cyc, b_sgnt, b_mreq, exp_gnt, b_req & ~full);
            end
            checks++;
            if (b_maddr !== (b_addr & 32'hFFFF_FFF8) || b_mdata !== b_wdata || b_mbe !== b_be) begin
                failures++;
                $display("FAIL rnd_request: cyc %0d got addr=%h data=%h be=%h expected %h/%h/%h",
                         cyc, b_maddr, b_mdata, b_mbe, b_addr & 32'hFFFF_FFF8, b_wdata, b_be);
            end
            hs_resp = b_rvalid & b_rready;
            if (hs_resp) begin
                checks++;
                if (b_srdata !== (bq[0] ? 64'h0 : b_mrdata)) begin
                    failures++;
                    $display("FAIL rnd_data: cyc %0d got %h expected %h",
                             cyc, b_srdata, bq[0] ? 64'h0 : b_mrdata);
                end
                void'(bq.pop_front());
                done++;
            end
            hs_req = b_req & exp_gnt;
            if (hs_req) bq.push_back(b_wen);
            hs_last = hs_resp;
            if (bq.size() > max_cnt) max_cnt = bq.size();
            step();
            checks++;
            if (b_outst !== 2'(bq.size())) begin
                failures++; $display("FAIL rnd_outstanding: cyc %0d got %0d expected %0d", cyc, b_outst, bq.size());
            end
        end
        b_req = 1'b0; b_rvalid = 1'b0;
        checks++;
        if (done < 1000) begin
            failures++; $display("FAIL rnd_timeout: got %0d responses expected 1000", done);
        end
        checks++;
        if (max_cnt != 3) begin
            failures++; $display("FAIL rnd_fill: got peak %0d expected 3", max_cnt);
        end
        checks++;
        if (b_err !== 1'b0) begin
            failures++; $display("FAIL rnd_err: got %b expected 0", b_err);
        end
    endtask

    initial begin
        test_reset();
        test_request_path();
        test_write();
        test_back_to_back();
        test_stall();
        test_backpressure();
        test_error();
        test_random_ratio1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
